// File: rtl/char_renderer_if.sv
// char_renderer_if -- bundle of every non-clock signal of the character renderer.
//   start/char_x/char_y  : render request from the host (host -> renderer)
//   busy/done            : render status (renderer -> host)
//   glyph_x/glyph_y      : offsets presented to the glyph decoder (renderer -> decoder)
//   glyph_colour/_enable : combinational decoder answer (decoder -> renderer)
//   vga_x/vga_y/vga_colour/plot, plot_ready : pixel write port with ready handshake
// The master modport is the environment (host + decoder + frame buffer);
// the slave modport is the renderer itself.
interface char_renderer_if;
  logic       start;
  logic [7:0] char_x;
  logic [7:0] char_y;
  logic       busy;
  logic       done;
  logic [7:0] glyph_x;
  logic [7:0] glyph_y;
  logic [5:0] glyph_colour;
  logic       glyph_enable;
  logic [7:0] vga_x;
  logic [7:0] vga_y;
  logic [5:0] vga_colour;
  logic       plot;
  logic       plot_ready;

  modport master (
    output start, char_x, char_y, glyph_colour, glyph_enable, plot_ready,
    input  busy, done, glyph_x, glyph_y, vga_x, vga_y, vga_colour, plot
  );

  modport slave (
    input  start, char_x, char_y, glyph_colour, glyph_enable, plot_ready,
    output busy, done, glyph_x, glyph_y, vga_x, vga_y, vga_colour, plot
  );
endinterface

// File: rtl/char_renderer.sv
// char_renderer -- walks one CELL_W x CELL_H glyph cell in raster order and
// emits one pixel write per visible offset (or per offset when BG_FILL=1).
// Ports:
//   clock  : sole clock, rising edge
//   resetn : asynchronous active-low reset
//   bus    : char_renderer_if.slave (request, status, glyph decoder, pixel write)
// Every output is a register. Each pixel costs a FETCH cycle (offsets stable
// at the decoder) and a PLOT cycle (write presented, held until accepted).
module char_renderer #(
  parameter int          CELL_W    = 8,
  parameter int          CELL_H    = 10,
  parameter int          BG_FILL   = 0,
  parameter logic [5:0]  BG_COLOUR = 6'b000000
) (
  input  logic           clock,
  input  logic           resetn,
  char_renderer_if.slave bus
);

  localparam logic [7:0] LAST_COL = 8'(CELL_W - 1);
  localparam logic [7:0] LAST_ROW = 8'(CELL_H - 1);

  typedef enum logic [1:0] {IDLE, FETCH, PLOT, DONE} state_t;

  state_t     state, state_n;
  logic [7:0] cx, cx_n, cy, cy_n;
  logic [7:0] col, col_n, row, row_n;
  logic [7:0] gx, gx_n, gy, gy_n;
  logic [7:0] vx, vx_n, vy, vy_n;
  logic [5:0] vc, vc_n;
  logic       plot, plot_n;
  logic       busy, busy_n;
  logic       done, done_n;

  // Position of the following pixel in raster order (col fastest).
  logic       last_col, last_row;
  logic [7:0] adv_col, adv_row;
  assign last_col = (col == LAST_COL);
  assign last_row = (row == LAST_ROW);
  assign adv_col  = last_col ? 8'd0 : col + 8'd1;
  assign adv_row  = last_col ? row + 8'd1 : row;

  // A PLOT cycle completes on a handshake, or immediately for a skipped pixel.
  logic plot_done;
  assign plot_done = !plot || bus.plot_ready;

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_n;
  end

  always_comb begin
    state_n = state;
    cx_n    = cx;
    cy_n    = cy;
    col_n   = col;
    row_n   = row;
    gx_n    = gx;
    gy_n    = gy;
    vx_n    = vx;
    vy_n    = vy;
    vc_n    = vc;
    plot_n  = plot;
    busy_n  = busy;
    done_n  = 1'b0;
    case (state)
      IDLE: begin
        if (bus.start) begin
          state_n = FETCH;
          cx_n    = bus.char_x;
          cy_n    = bus.char_y;
          col_n   = 8'd0;
          row_n   = 8'd0;
          gx_n    = 8'd0;
          gy_n    = 8'd0;
          busy_n  = 1'b1;
        end
      end
      FETCH: begin
        // Decoder output is valid now because glyph_x/y were registered on
        // the edge that entered FETCH.
        state_n = PLOT;
        vx_n    = cx + col;
        vy_n    = cy + row;
        if (bus.glyph_enable) begin
          vc_n   = bus.glyph_colour;
          plot_n = 1'b1;
        end else if (BG_FILL != 0) begin
          vc_n   = BG_COLOUR;
          plot_n = 1'b1;
        end else begin
          plot_n = 1'b0;
        end
      end
      PLOT: begin
        if (plot_done) begin
          plot_n = 1'b0;
          if (last_col && last_row) begin
            state_n = DONE;
            busy_n  = 1'b0;
            done_n  = 1'b1;
          end else begin
            state_n = FETCH;
            col_n   = adv_col;
            row_n   = adv_row;
            gx_n    = adv_col;
            gy_n    = adv_row;
          end
        end
      end
      DONE: begin
        state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge resetn) begin
    if (!resetn) begin
      cx   <= 8'd0;
      cy   <= 8'd0;
      col  <= 8'd0;
      row  <= 8'd0;
      gx   <= 8'd0;
      gy   <= 8'd0;
      vx   <= 8'd0;
      vy   <= 8'd0;
      vc   <= 6'd0;
      plot <= 1'b0;
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      cx   <= cx_n;
      cy   <= cy_n;
      col  <= col_n;
      row  <= row_n;
      gx   <= gx_n;
      gy   <= gy_n;
      vx   <= vx_n;
      vy   <= vy_n;
      vc   <= vc_n;
      plot <= plot_n;
      busy <= busy_n;
      done <= done_n;
    end
  end

  assign bus.glyph_x    = gx;
  assign bus.glyph_y    = gy;
  assign bus.vga_x      = vx;
  assign bus.vga_y      = vy;
  assign bus.vga_colour = vc;
  assign bus.plot       = plot;
  assign bus.busy       = busy;
  assign bus.done       = done;

endmodule

// File: tb/tb_char_renderer.sv
// tb_char_renderer -- two renderers (BG_FILL=0 and BG_FILL=1) share one
// request stream; each has its own glyph decoder and write-ready source.
// Expected pixel lists are built from the glyph pattern and cell rules.
module tb_char_renderer;
  localparam int         W    = 8;
  localparam int         H    = 10;
  localparam int         NPIX = W * H;
  localparam logic [5:0] BGC  = 6'h15;

  typedef struct packed {
    logic [7:0] x;
    logic [7:0] y;
    logic [5:0] c;
  } pix_t;

  logic       clock  = 1'b0;
  logic       resetn = 1'b0;
  logic       start  = 1'b0;
  logic [7:0] cx_in  = 8'd0;
  logic [7:0] cy_in  = 8'd0;
  logic [1:0] rdy    = 2'b11;

  char_renderer_if b0();
  char_renderer_if b1();

  char_renderer #(.CELL_W(W), .CELL_H(H), .BG_FILL(0), .BG_COLOUR(BGC)) dut0 (
    .clock(clock), .resetn(resetn), .bus(b0));
  char_renderer #(.CELL_W(W), .CELL_H(H), .BG_FILL(1), .BG_COLOUR(BGC)) dut1 (
    .clock(clock), .resetn(resetn), .bus(b1));

  always #5 clock = ~clock;

  // "M" glyph: row masks, bit c = column c.
  function automatic logic gl_en(input logic [7:0] gx, input logic [7:0] gy);
    logic [7:0] m;
    if (gx >= 8'(W) || gy >= 8'(H)) return 1'b0;
    case (gy)
      8'd0, 8'd1: m = 8'hCC;
      8'd2, 8'd3: m = 8'hB4;
      default:    m = 8'h84;
    endcase
    return m[gx[2:0]];
  endfunction

  function automatic logic [5:0] gl_col(input logic [7:0] gx, input logic [7:0] gy);
    return 6'(int'(gx) * 5 + int'(gy) * 11 + 3);
  endfunction

  assign b0.start = start;  assign b1.start = start;
  assign b0.char_x = cx_in; assign b1.char_x = cx_in;
  assign b0.char_y = cy_in; assign b1.char_y = cy_in;
  assign b0.plot_ready = rdy[0];
  assign b1.plot_ready = rdy[1];
  assign b0.glyph_enable = gl_en(b0.glyph_x, b0.glyph_y);
  assign b1.glyph_enable = gl_en(b1.glyph_x, b1.glyph_y);
  assign b0.glyph_colour = gl_col(b0.glyph_x, b0.glyph_y);
  assign b1.glyph_colour = gl_col(b1.glyph_x, b1.glyph_y);

  logic [1:0]      o_plot, o_busy, o_done;
  logic [1:0][7:0] o_vx, o_vy, o_gx, o_gy;
  logic [1:0][5:0] o_vc;
  assign o_plot = {b1.plot, b0.plot};
  assign o_busy = {b1.busy, b0.busy};
  assign o_done = {b1.done, b0.done};
  assign o_vx   = {b1.vga_x, b0.vga_x};
  assign o_vy   = {b1.vga_y, b0.vga_y};
  assign o_vc   = {b1.vga_colour, b0.vga_colour};
  assign o_gx   = {b1.glyph_x, b0.glyph_x};
  assign o_gy   = {b1.glyph_y, b0.glyph_y};

  // Model state per instance
  pix_t expv [2][0:NPIX-1];
  int   exp_n [2], exp_rd [2], writes [2];
  int   busy_cnt [2], stall_cnt [2], last_busy [2], last_stall [2], stall_left [2];
  bit   cell_done [2], prev_hold [2], prev_done [2];
  pix_t prev_pix [2];
  int   mode   = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk_eq(input string nm, input int act, input int want);
    checks++;
    if (act != want) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, act, want);
    end
  endtask

  // Expected write list: raster order, wrapped coordinates, colour rule.
  task automatic build(input int i, input logic [7:0] cx, input logic [7:0] cy, input bit bg);
    int n;
    logic en;
    n = 0;
    for (int r = 0; r < H; r++)
      for (int c = 0; c < W; c++) begin
        en = gl_en(8'(c), 8'(r));
        if (en || bg) begin
          expv[i][n] = '{x: cx + 8'(c), y: cy + 8'(r), c: en ? gl_col(8'(c), 8'(r)) : BGC};
          n++;
        end
      end
    exp_n[i]  = n;
    exp_rd[i] = 0;
  endtask

  // Write-ready source, updated just after each rising edge.
  initial forever begin
    @(posedge clock);
    #1;
    for (int i = 0; i < 2; i++) begin
      case (mode)
        1: rdy[i] = ($urandom_range(0, 3) != 0);
        2: if (o_plot[i] && writes[i] == 0 && stall_left[i] > 0) begin
             rdy[i] = 1'b0;
             stall_left[i]--;
           end else rdy[i] = 1'b1;
        default: rdy[i] = 1'b1;
      endcase
    end
  end

  // Per-cycle compare against the model.
  initial forever begin
    @(negedge clock);
    if (!resetn) begin
      for (int i = 0; i < 2; i++) begin
        prev_hold[i] = 1'b0; prev_done[i] = 1'b0;
        busy_cnt[i]  = 0;    stall_cnt[i] = 0;
      end
    end else begin
      for (int i = 0; i < 2; i++) begin
        pix_t cur;
        cur = '{x: o_vx[i], y: o_vy[i], c: o_vc[i]};
        if (prev_hold[i]) begin
          chk_eq($sformatf("stall_hold_plot%0d", i), int'(o_plot[i]), 1);
          chk_eq($sformatf("stall_hold_pix%0d", i), int'(cur), int'(prev_pix[i]));
        end
        if (o_plot[i] && rdy[i]) begin
          chk_eq($sformatf("write_in_range%0d", i), int'(exp_rd[i] < exp_n[i]), 1);
          if (exp_rd[i] < exp_n[i])
            chk_eq($sformatf("write%0d_pix%0d", i, exp_rd[i]), int'(cur), int'(expv[i][exp_rd[i]]));
          exp_rd[i]++;
          writes[i]++;
        end
        if (!o_busy[i]) chk_eq($sformatf("plot_idle%0d", i), int'(o_plot[i]), 0);
        else busy_cnt[i]++;
        if (o_plot[i] && !rdy[i]) stall_cnt[i]++;
        if (o_done[i]) begin
          chk_eq($sformatf("done_pulse%0d", i), int'(prev_done[i]), 0);
          chk_eq($sformatf("busy_at_done%0d", i), int'(o_busy[i]), 0);
          chk_eq($sformatf("writes_at_done%0d", i), exp_rd[i], exp_n[i]);
          chk_eq($sformatf("cycles_to_done%0d", i), busy_cnt[i], 2 * NPIX + stall_cnt[i]);
          last_busy[i]  = busy_cnt[i];
          last_stall[i] = stall_cnt[i];
          busy_cnt[i]   = 0;
          stall_cnt[i]  = 0;
          cell_done[i]  = 1'b1;
        end
        prev_hold[i] = o_plot[i] && !rdy[i];
        prev_pix[i]  = cur;
        prev_done[i] = o_done[i];
      end
    end
  end

  task automatic begin_cell(input logic [7:0] cx, input logic [7:0] cy, input int md);
    @(posedge clock);
    #2;
    mode = md;
    for (int i = 0; i < 2; i++) begin
      stall_left[i] = 5; writes[i] = 0; cell_done[i] = 1'b0;
    end
    build(0, cx, cy, 1'b0);
    build(1, cx, cy, 1'b1);
    start = 1'b1; cx_in = cx; cy_in = cy;
  endtask

  task automatic run_cell(input logic [7:0] cx, input logic [7:0] cy, input int md, input int hold);
    int t;
    begin_cell(cx, cy, md);
    repeat (hold) @(posedge clock);
    #2;
    start = 1'b0; cx_in = 8'($urandom); cy_in = 8'($urandom);
    t = 0;
    while (!(cell_done[0] && cell_done[1]) && t < 3000) begin
      @(posedge clock);
      t++;
    end
    chk_eq("cell_finished", int'(cell_done[0] && cell_done[1]), 1);
    repeat (3) @(posedge clock);
  endtask

  initial begin
    int t, w0, w1;
    #12;
    for (int i = 0; i < 2; i++) begin
      chk_eq($sformatf("rst_plot%0d", i), int'(o_plot[i]), 0);
      chk_eq($sformatf("rst_busy%0d", i), int'(o_busy[i]), 0);
      chk_eq($sformatf("rst_done%0d", i), int'(o_done[i]), 0);
      chk_eq($sformatf("rst_vga%0d", i), int'({o_vx[i], o_vy[i], o_vc[i]}), 0);
      chk_eq($sformatf("rst_glyph%0d", i), int'({o_gx[i], o_gy[i]}), 0);
    end
    #5 resetn = 1'b1;

    // "M" cell, ready always high
    run_cell(8'h10, 8'h20, 0, 1);
    chk_eq("m_model_count", exp_n[0], 28);
    chk_eq("m_first_xy", int'({expv[0][0].x, expv[0][0].y}), 16'h1220);
    chk_eq("m_last_xy", int'({expv[0][27].x, expv[0][27].y}), 16'h1729);
    chk_eq("m_bg_model_count", exp_n[1], 80);
    chk_eq("m_bg_transparent_colour", int'(expv[1][0].c), 6'h15);
    chk_eq("m_writes0", writes[0], 28);
    chk_eq("m_writes1", writes[1], 80);
    chk_eq("m_cycles0", last_busy[0], 160);
    chk_eq("m_cycles1", last_busy[1], 160);

    // first write stalled for 5 cycles
    run_cell(8'h10, 8'h20, 2, 1);
    for (int i = 0; i < 2; i++) begin
      chk_eq($sformatf("stall_cycles%0d", i), last_stall[i], 5);
      chk_eq($sformatf("stall_total%0d", i), last_busy[i], 165);
    end
    chk_eq("stall_writes0", writes[0], 28);

    // coordinate wrap
    run_cell(8'hFC, 8'hFE, 0, 1);
    chk_eq("wrap_model_x", int'({expv[1][4].x, expv[1][4].y}), 16'h00FE);
    chk_eq("wrap_model_xy", int'({expv[1][20].x, expv[1][20].y}), 16'h0000);

    // random cells, random ready, start held into busy
    repeat (6) run_cell(8'($urandom), 8'($urandom), 1, int'($urandom_range(1, 8)));

    // reset in the middle of a cell
    begin_cell(8'h40, 8'h50, 0);
    @(posedge clock);
    #2;
    start = 1'b0;
    t = 0;
    while (writes[1] < 30 && t < 2000) begin
      @(posedge clock);
      t++;
    end
    chk_eq("reached_pixel30", int'(writes[1] >= 30), 1);
    #3 resetn = 1'b0;
    #1;
    for (int i = 0; i < 2; i++) begin
      chk_eq($sformatf("async_rst_plot%0d", i), int'(o_plot[i]), 0);
      chk_eq($sformatf("async_rst_busy%0d", i), int'(o_busy[i]), 0);
      chk_eq($sformatf("async_rst_vga%0d", i), int'({o_vx[i], o_vy[i], o_vc[i]}), 0);
      exp_n[i] = 0; exp_rd[i] = 0;
    end
    #10 resetn = 1'b1;
    w0 = writes[0]; w1 = writes[1];
    repeat (20) @(posedge clock);
    #2;
    chk_eq("post_rst_writes0", writes[0], w0);
    chk_eq("post_rst_writes1", writes[1], w1);
    chk_eq("post_rst_busy", int'(o_busy), 0);

    // renderer still works after the abandoned cell
    run_cell(8'h33, 8'h44, 1, 3);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/char_renderer.md
CHAR_RENDERER -- requirements
Module: char_renderer

Interface
REQ-001 Parameter CELL_W, default 8, glyph cell width in pixels (glyph_x range 0..CELL_W-1).
REQ-002 Parameter CELL_H, default 10, glyph cell height in pixels (glyph_y range 0..CELL_H-1).
REQ-003 Parameter BG_FILL, default 0, 1 = write BG_COLOUR for transparent pixels, 0 = skip them.
REQ-004 Parameter BG_COLOUR, default 6'b000000, background colour used when BG_FILL=1.
REQ-005 One clock; reset is asynchronous and active-low. Ports are clock and resetn.
REQ-006 clock  input  1  sole clock, rising edge.
REQ-007 resetn  input  1  asynchronous active-low reset.
REQ-008 start  input  1  request to render one character cell; sampled only in IDLE.
REQ-009 char_x  input  8  screen x of cell top-left; latched on accepted start.
REQ-010 char_y  input  8  screen y of cell top-left; latched on accepted start.
REQ-011 glyph_x  output  8  column offset presented to the glyph decoder.
REQ-012 glyph_y  output  8  row offset presented to the glyph decoder.
REQ-013 glyph_colour  input  6  decoder colour for the current offset, combinational from glyph_x/glyph_y.
REQ-014 glyph_enable  input  1  decoder pixel-present flag for the current offset.
REQ-015 vga_x  output  8  pixel write x.
REQ-016 vga_y  output  8  pixel write y.
REQ-017 vga_colour  output  6  pixel write colour.
REQ-018 plot  output  1  pixel write valid.
REQ-019 plot_ready  input  1  downstream accepts the write on a cycle where plot=1 and plot_ready=1.
REQ-020 busy  output  1  high from the cycle after an accepted start until done.
REQ-021 done  output  1  single-cycle pulse when the cell is finished.

Function
REQ-022 FSM states: IDLE, FETCH, PLOT, DONE; all outputs registered.
REQ-023 IDLE: start=1 latches char_x/char_y, clears col/row to 0, moves to FETCH, and sets busy=1 on the next edge.
REQ-024 start while busy=1 or done=1 is ignored and is not queued.
REQ-025 FETCH: glyph_x=col and glyph_y=row are driven. The block then moves to PLOT after one cycle so the decoder output is sampled with stable offsets.
REQ-026 FETCH->PLOT edge registers vga_x=(char_x+col) mod 256, vga_y=(char_y+row) mod 256. Both sums wrap at 8 bits with no carry-out.
REQ-027 FETCH->PLOT edge colour rule: glyph_enable=1 gives vga_colour=glyph_colour and plot=1.
REQ-028 FETCH->PLOT edge colour rule: glyph_enable=0 with BG_FILL=1 gives vga_colour=BG_COLOUR and plot=1.
REQ-029 FETCH->PLOT edge colour rule: glyph_enable=0 with BG_FILL=0 gives plot=0, and PLOT completes in one cycle without a handshake.
REQ-030 PLOT with plot=1 and plot_ready=0: vga_x, vga_y, vga_colour and plot are held unchanged, with no advance.
REQ-031 PLOT completion (handshake or skip) advances col to col+1 if col<CELL_W-1. Otherwise col=0 and row=row+1. The next state is FETCH, and plot drops to 0 on the same edge.
REQ-032 Completion at col=CELL_W-1, row=CELL_H-1 goes to DONE instead of FETCH.
REQ-033 Pixel order is raster: row-major, col fastest.
REQ-034 Minimum throughput is 2 cycles per pixel, so a full cell with plot_ready tied high takes 2*CELL_W*CELL_H cycles from the first FETCH to DONE.
REQ-035 DONE lasts one cycle: done=1, busy=0, plot=0; then IDLE.
REQ-036 glyph_x and glyph_y hold their last values outside FETCH.
REQ-037 Total writes per cell: CELL_W*CELL_H when BG_FILL=1; with BG_FILL=0, equal to the number of glyph_enable=1 offsets.

Reset
REQ-038 resetn=0 forces IDLE immediately, regardless of edge.
REQ-039 Reset values: plot=0, busy=0, done=0, vga_x=0, vga_y=0, vga_colour=0, glyph_x=0, glyph_y=0, col=0, row=0.
REQ-040 Reset mid-cell abandons the cell; after release no further writes occur until a new start.

Verification
REQ-041 Glyph model "M" pattern, char_x=0x10, char_y=0x20, BG_FILL=0, plot_ready=1 -> exactly 28 writes. First write at (0x12,0x20) and last at (0x17,0x29). done pulses once after 160 cycles; busy drops with done.
REQ-042 Same stimulus with BG_FILL=1, BG_COLOUR=6'h15 -> 80 writes in raster order; transparent pixels carry colour 6'h15.
REQ-043 plot_ready low for 5 cycles on the first write -> vga_x, vga_y, vga_colour and plot are stable for those 5 cycles; col does not advance; the write is accepted exactly once.
REQ-044 char_x=0xFC, char_y=0xFE -> column offset 4 writes vga_x=0x00; row offset 2 writes vga_y=0x00. No other side effects.
REQ-045 resetn pulsed low at pixel 30 -> plot=0 asynchronously; after release the state is IDLE with no writes. A start pulse held during busy produces no second render.
